// File: rtl/reindeer_pipeline_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reindeer_pipeline_sequencer_pkg
//  Description : Shared types and constants for the Reindeer stage sequencer.
//                The eight sequencer states fit a 3-bit binary encoding
//                because both long waits (memory and mul/div) share one
//                wait state. A separate flag records which done input ends
//                the wait.
//  Revision    : 1.0 - initial release
// ============================================================================
package reindeer_pipeline_sequencer_pkg;

    localparam int c_TIMEOUT_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_WAIT   = 3'd4,
        SEQ_WB     = 3'd5,
        SEQ_SLEEP  = 3'd6,
        SEQ_TRAP   = 3'd7
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/reindeer_pipeline_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reindeer_pipeline_sequencer_if
//  Description : Control bundle between the stage sequencer (master) and the
//                core datapath / decode / interrupt logic (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reindeer_pipeline_sequencer_if;

    logic start;
    logic fetch_ack;
    logic ctl_LOAD;
    logic ctl_STORE;
    logic ctl_MUL_DIV;
    logic ctl_WFI;
    logic mem_done;
    logic mul_div_done;
    logic interrupt_pending;

    logic fetch_enable;
    logic decode_enable;
    logic exe_enable;
    logic mem_enable;
    logic wb_enable;
    logic trap_enable;
    logic wait_timeout;
    logic busy;

    modport master (
        input  start, fetch_ack, ctl_LOAD, ctl_STORE, ctl_MUL_DIV, ctl_WFI,
               mem_done, mul_div_done, interrupt_pending,
        output fetch_enable, decode_enable, exe_enable, mem_enable,
               wb_enable, trap_enable, wait_timeout, busy
    );

    modport slave (
        output start, fetch_ack, ctl_LOAD, ctl_STORE, ctl_MUL_DIV, ctl_WFI,
               mem_done, mul_div_done, interrupt_pending,
        input  fetch_enable, decode_enable, exe_enable, mem_enable,
               wb_enable, trap_enable, wait_timeout, busy
    );

endinterface
`default_nettype wire

// File: rtl/reindeer_wait_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : reindeer_wait_watchdog
//  Description : Saturating wait-cycle counter. Reads 0 in the first wait
//                cycle after a clear and advances once per enabled cycle.
//                The expired flag is raised while the count sits at its
//                all-ones maximum, so the wait is abandoned at the end of
//                the wait cycle in which the count reaches 2**TIMEOUT_BITS-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module reindeer_wait_watchdog
    import reindeer_pipeline_sequencer_pkg::*;
#(
    parameter int TIMEOUT_BITS = c_TIMEOUT_BITS_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam logic [TIMEOUT_BITS-1:0] c_MAX = {TIMEOUT_BITS{1'b1}};

    logic [TIMEOUT_BITS-1:0] r_count;

    // Count wait cycles; clear has priority and the count holds at maximum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_MAX);

endmodule
`default_nettype wire

// File: rtl/reindeer_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reindeer_pipeline_sequencer
//  Description : Multi-cycle stage sequencer for the Reindeer core. It steps
//                one instruction at a time through fetch, decode, execute,
//                an optional memory or mul/div wait, and write-back, with
//                one-cycle registered enable strobes. It also handles WFI
//                sleep, interrupt entry and a wait watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module reindeer_pipeline_sequencer
    import reindeer_pipeline_sequencer_pkg::*;
#(
    parameter int TIMEOUT_BITS = c_TIMEOUT_BITS_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic sync_reset,
    reindeer_pipeline_sequencer_if.master bus
);

    seq_state_t r_state;
    logic       r_wait_is_mem;     // 1: wait ends on mem_done, 0: on mul_div_done
    logic       r_fetch_enable;
    logic       r_decode_enable;
    logic       r_exe_enable;
    logic       r_mem_enable;
    logic       r_wb_enable;
    logic       r_trap_enable;
    logic       r_wait_timeout;
    logic       r_busy;

    logic w_mem_op;
    logic w_wait_entry;
    logic w_wait_done;
    logic w_wd_expired;

    assign w_mem_op     = bus.ctl_LOAD | bus.ctl_STORE;
    assign w_wait_entry = (r_state == SEQ_EXEC) && (w_mem_op || bus.ctl_MUL_DIV);
    assign w_wait_done  = r_wait_is_mem ? bus.mem_done : bus.mul_div_done;

    // The clear lands on the edge that enters the wait, so the count is 0 in the first wait cycle
    reindeer_wait_watchdog #(
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (sync_reset | w_wait_entry),
        .i_enable  (r_state == SEQ_WAIT),
        .o_expired (w_wd_expired)
    );

    // Sequencer state machine; every strobe is registered and set only on entry to its state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= SEQ_IDLE;
            r_wait_is_mem   <= 1'b0;
            r_fetch_enable  <= 1'b0;
            r_decode_enable <= 1'b0;
            r_exe_enable    <= 1'b0;
            r_mem_enable    <= 1'b0;
            r_wb_enable     <= 1'b0;
            r_trap_enable   <= 1'b0;
            r_wait_timeout  <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_fetch_enable  <= 1'b0;
            r_decode_enable <= 1'b0;
            r_exe_enable    <= 1'b0;
            r_mem_enable    <= 1'b0;
            r_wb_enable     <= 1'b0;
            r_trap_enable   <= 1'b0;
            r_wait_timeout  <= 1'b0;
            if (sync_reset) begin
                r_state       <= SEQ_IDLE;
                r_wait_is_mem <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                // Only IDLE without a start request leaves the sequencer idle
                r_busy <= !((r_state == SEQ_IDLE) && !bus.start);
                case (r_state)
                    SEQ_IDLE: begin
                        if (bus.start) begin
                            r_state        <= SEQ_FETCH;
                            r_fetch_enable <= 1'b1;
                        end
                    end
                    SEQ_FETCH: begin
                        if (bus.fetch_ack) begin
                            r_state         <= SEQ_DECODE;
                            r_decode_enable <= 1'b1;
                        end
                    end
                    SEQ_DECODE: begin
                        r_state      <= SEQ_EXEC;
                        r_exe_enable <= 1'b1;
                    end
                    SEQ_EXEC: begin
                        // Load/store wins over mul/div when decode flags both
                        if (w_mem_op) begin
                            r_state       <= SEQ_WAIT;
                            r_wait_is_mem <= 1'b1;
                            r_mem_enable  <= 1'b1;
                        end else if (bus.ctl_MUL_DIV) begin
                            r_state       <= SEQ_WAIT;
                            r_wait_is_mem <= 1'b0;
                        end else begin
                            r_state     <= SEQ_WB;
                            r_wb_enable <= 1'b1;
                        end
                    end
                    SEQ_WAIT: begin
                        // A done arriving in the expiry cycle still commits normally
                        if (w_wait_done) begin
                            r_state     <= SEQ_WB;
                            r_wb_enable <= 1'b1;
                        end else if (w_wd_expired) begin
                            r_state        <= SEQ_FETCH;
                            r_fetch_enable <= 1'b1;
                            r_wait_timeout <= 1'b1;
                        end
                    end
                    SEQ_WB: begin
                        if (bus.interrupt_pending) begin
                            r_state       <= SEQ_TRAP;
                            r_trap_enable <= 1'b1;
                        end else if (bus.ctl_WFI) begin
                            r_state <= SEQ_SLEEP;
                        end else begin
                            r_state        <= SEQ_FETCH;
                            r_fetch_enable <= 1'b1;
                        end
                    end
                    SEQ_SLEEP: begin
                        if (bus.interrupt_pending) begin
                            r_state       <= SEQ_TRAP;
                            r_trap_enable <= 1'b1;
                        end
                    end
                    SEQ_TRAP: begin
                        r_state        <= SEQ_FETCH;
                        r_fetch_enable <= 1'b1;
                    end
                    default: begin
                        r_state <= SEQ_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.fetch_enable  = r_fetch_enable;
    assign bus.decode_enable = r_decode_enable;
    assign bus.exe_enable    = r_exe_enable;
    assign bus.mem_enable    = r_mem_enable;
    assign bus.wb_enable     = r_wb_enable;
    assign bus.trap_enable   = r_trap_enable;
    assign bus.wait_timeout  = r_wait_timeout;
    assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reindeer_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reindeer_pipeline_sequencer
//  Description : Scoreboard bench. The driver plans each instruction as a
//                timeline of strobe events (cycle numbers from the stage
//                rules) and queues them; a negedge monitor pops and compares
//                whatever the sequencer shows. Inputs that the current stage
//                must ignore carry random noise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reindeer_pipeline_sequencer;

    localparam int         c_WAIT_LIMIT = 255;
    localparam logic [6:0] c_V_FETCH    = 7'b100_0000;
    localparam logic [6:0] c_V_DECODE   = 7'b010_0000;
    localparam logic [6:0] c_V_EXE      = 7'b001_0000;
    localparam logic [6:0] c_V_MEM      = 7'b000_1000;
    localparam logic [6:0] c_V_WB       = 7'b000_0100;
    localparam logic [6:0] c_V_TRAP     = 7'b000_0010;
    localparam logic [6:0] c_V_TO       = 7'b000_0001;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic sync_reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   idle_mode = 1'b1;
    bit   irq_noise = 1'b0;
    ev_t  q[$];

    reindeer_pipeline_sequencer_if bus();

    reindeer_pipeline_sequencer #(
        .TIMEOUT_BITS (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    wire logic [6:0] w_strobes = {bus.fetch_enable, bus.decode_enable, bus.exe_enable,
                                  bus.mem_enable, bus.wb_enable, bus.trap_enable,
                                  bus.wait_timeout};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic [6:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        q.push_back(e);
    endfunction

    // Monitor: compare every strobe cycle against the planned timeline
    always @(negedge clk) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_strobe cycle %0d: got none, required %b", q[0].cyc, q[0].vec);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                checks++;
                if (w_strobes !== q[0].vec || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL strobe cycle %0d: got %b busy %b, required %b busy 1",
                             cyc, w_strobes, bus.busy, q[0].vec);
                end
                void'(q.pop_front());
            end else if (w_strobes !== 7'd0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe cycle %0d: got %b, required 0000000", cyc, w_strobes);
            end
        end
    end

    task automatic check_outputs(input string name, input logic [6:0] exp_s, input logic exp_b);
        checks++;
        if (w_strobes !== exp_s || bus.busy !== exp_b) begin
            errors++;
            $display("FAIL %s cycle %0d: got strobes %b busy %b, required strobes %b busy %b",
                     name, cyc, w_strobes, bus.busy, exp_s, exp_b);
        end
    endtask

    // Advance one cycle and put noise on inputs the sequencer should ignore
    task automatic tick();
        @(posedge clk);
        #1;
        bus.fetch_ack    = 1'($urandom_range(0, 1));
        bus.ctl_LOAD     = 1'($urandom_range(0, 1));
        bus.ctl_STORE    = 1'($urandom_range(0, 1));
        bus.ctl_MUL_DIV  = 1'($urandom_range(0, 1));
        bus.ctl_WFI      = 1'($urandom_range(0, 1));
        bus.mem_done     = 1'($urandom_range(0, 1));
        bus.mul_div_done = 1'($urandom_range(0, 1));
        bus.start        = idle_mode ? 1'b0 : 1'($urandom_range(0, 1));
        if (irq_noise) bus.interrupt_pending = 1'($urandom_range(0, 1));
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic launch(output int f);
        irq_noise = 1'b0;
        bus.interrupt_pending = 1'b0;
        goto(cyc + 1);
        bus.start = 1'b1;
        idle_mode = 1'b0;
        f = cyc + 1;
        push(f, c_V_FETCH);
    endtask

    // kind: 0 ALU, 1 LOAD, 2 STORE, 3 MUL/DIV, 4 LOAD+MUL/DIV flags
    // d: done delay in wait cycles (<0: never)
    // wb_mode: 0 continue, 1 irq (WFI random), 2 WFI sleep for s cycles, 3 irq with WFI
    task automatic run_instr(input int f, input int kind, input int a, input int d,
                             input int wb_mode, input int s, output int next_f);
        int dec_c, exe_c, wait_c, wb_c, trap_c, lim;
        bit is_mem, timeout;
        is_mem  = (kind == 1 || kind == 2 || kind == 4);
        timeout = (kind != 0 && d < 0);
        dec_c   = f + a + 1;
        exe_c   = dec_c + 1;
        wait_c  = exe_c + 1;
        wb_c    = 0;
        trap_c  = 0;
        push(dec_c, c_V_DECODE);
        push(exe_c, c_V_EXE);
        if (is_mem) push(wait_c, c_V_MEM);
        if (timeout) begin
            next_f = wait_c + c_WAIT_LIMIT + 1;
            push(next_f, c_V_FETCH | c_V_TO);
        end else begin
            wb_c = (kind == 0) ? exe_c + 1 : wait_c + d + 1;
            push(wb_c, c_V_WB);
            if (wb_mode == 0) begin
                next_f = wb_c + 1;
            end else begin
                trap_c = (wb_mode == 2) ? wb_c + 2 + s : wb_c + 1;
                push(trap_c, c_V_TRAP);
                next_f = trap_c + 1;
            end
            push(next_f, c_V_FETCH);
        end

        irq_noise = 1'b1;
        for (int c = f; c <= f + a; c++) begin
            goto(c);
            bus.fetch_ack = (c == f + a);
        end
        goto(exe_c);
        bus.ctl_LOAD    = (kind == 1 || kind == 4);
        bus.ctl_STORE   = (kind == 2);
        bus.ctl_MUL_DIV = (kind == 3 || kind == 4);
        if (kind != 0) begin
            lim = timeout ? c_WAIT_LIMIT : d;
            for (int k = 0; k <= lim; k++) begin
                goto(wait_c + k);
                if (is_mem) bus.mem_done = !timeout && (k == d);
                else        bus.mul_div_done = !timeout && (k == d);
            end
        end
        irq_noise = 1'b0;
        if (!timeout) begin
            goto(wb_c);
            case (wb_mode)
                0: begin
                    bus.ctl_WFI = 1'b0;
                    bus.interrupt_pending = 1'b0;
                end
                1: bus.interrupt_pending = 1'b1;
                2: begin
                    bus.ctl_WFI = 1'b1;
                    bus.interrupt_pending = 1'b0;
                end
                default: begin
                    bus.ctl_WFI = 1'b1;
                    bus.interrupt_pending = 1'b1;
                end
            endcase
            if (wb_mode == 2) begin
                goto(wb_c + 1 + s);
                check_outputs("sleep_quiet", 7'd0, 1'b1);
                bus.interrupt_pending = 1'b1;
            end
            if (wb_mode != 0) begin
                goto(trap_c);
                bus.interrupt_pending = 1'b0;
            end
        end else begin
            bus.interrupt_pending = 1'b0;
        end
    endtask

    // Start a LOAD and kill it with a reset in its first memory-wait cycle
    task automatic run_abort(input int f, input bit use_async);
        irq_noise = 1'b0;
        bus.interrupt_pending = 1'b0;
        push(f + 1, c_V_DECODE);
        push(f + 2, c_V_EXE);
        push(f + 3, c_V_MEM);
        goto(f);
        bus.fetch_ack = 1'b1;
        goto(f + 2);
        bus.ctl_LOAD    = 1'b1;
        bus.ctl_STORE   = 1'b0;
        bus.ctl_MUL_DIV = 1'b0;
        goto(f + 3);
        bus.mem_done = 1'b0;
        if (use_async) begin
            #6;
            reset = 1'b1;
            #1;
            check_outputs("async_reset_immediate", 7'd0, 1'b0);
            idle_mode = 1'b1;
            tick();
            check_outputs("async_reset_held", 7'd0, 1'b0);
            reset = 1'b0;
        end else begin
            goto(f + 4);
            sync_reset = 1'b1;
            #3;
            check_outputs("sync_reset_before_edge", 7'd0, 1'b1);
            idle_mode = 1'b1;
            goto(f + 5);
            sync_reset = 1'b0;
            check_outputs("sync_reset_after_edge", 7'd0, 1'b0);
        end
    endtask

    task automatic run_random(input int n, inout int f);
        int kind, a, d, m, s;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 4));
            a    = int'($urandom_range(0, 3));
            d    = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 12));
            m    = int'($urandom_range(0, 3));
            s    = int'($urandom_range(0, 10));
            run_instr(f, kind, a, d, m, s, f);
        end
    endtask

    initial begin
        int f;
        reset = 1'b1;
        sync_reset = 1'b0;
        bus.start = 1'b0;
        bus.fetch_ack = 1'b0;
        bus.ctl_LOAD = 1'b0;
        bus.ctl_STORE = 1'b0;
        bus.ctl_MUL_DIV = 1'b0;
        bus.ctl_WFI = 1'b0;
        bus.mem_done = 1'b0;
        bus.mul_div_done = 1'b0;
        bus.interrupt_pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset_state", 7'd0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        check_outputs("idle_ignores_noise", 7'd0, 1'b0);

        launch(f);
        run_instr(f, 0, 0, 0, 0, 0, f);     // ALU, fetch_ack with the request
        run_instr(f, 1, 0, 3, 0, 0, f);     // LOAD, done 3 cycles after mem_enable
        run_instr(f, 3, 1, -1, 0, 0, f);    // MUL/DIV never done: watchdog
        run_instr(f, 0, 0, 0, 2, 100, f);   // WFI sleep for 100 cycles
        run_instr(f, 0, 2, 0, 3, 0, f);     // interrupt together with WFI
        run_instr(f, 2, 0, 255, 0, 0, f);   // done in the expiry cycle
        run_instr(f, 2, 0, 0, 1, 0, f);     // STORE done at once, then interrupt
        run_instr(f, 4, 0, 5, 0, 0, f);     // LOAD+MUL/DIV flags take memory path
        run_instr(f, 3, 0, 7, 1, 0, f);     // MUL/DIV then interrupt
        run_instr(f, 1, 0, -1, 0, 0, f);    // LOAD never done: watchdog
        run_random(40, f);

        run_abort(f, 1'b1);
        launch(f);
        run_random(5, f);
        run_abort(f, 1'b0);
        launch(f);
        run_random(5, f);

        goto(f);
        bus.fetch_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no completion by cycle %0d, required completion", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
